// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS controller.
//   - opcode constants for the supported instruction set
//   - sequencer state encoding (13 states in a 4-bit register)
//   - ALU-op, ALU B-source and PC-source codes
//   - packed control word produced by mc_out_decode
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_REGB  = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic   pcwrite;
    logic   pcwritecond;
    pcsrc_t pcsrc;
    logic   iord;
    logic   memread;
    logic   memwrite;
    logic   irwrite;
    logic   alusrca;
    srcb_t  alusrcb;
    aluop_t aluop;
    logic   regdst;
    logic   memtoreg;
    logic   regwrite;
    logic   halt;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational state -> control word decode.
// Ports:
//   state_i      current sequencer state
//   mem_ready_i  memory handshake, only used to qualify the FETCH IR/PC load
//   ctrl_o       full datapath/memory control word (all fields 0 unless set)
module mc_out_decode
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        // IR and PC advance only on the cycle the fetch read completes
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.aluop       = ALU_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsrc       = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl_o.halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS sequencer (fetch/decode/execute/mem/wb).
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   opcode         IR[31:26], valid from DECODE onward
//   mem_ready      memory completes the current read/write this cycle
//   pcwrite, pcwritecond, pcsrc, iord, memread, memwrite, irwrite,
//   alusrca, alusrcb, aluop, regdst, memtoreg, regwrite   datapath controls
//   halt           sticky halted flag
//   state          current state (debug)
// Holds the state register and next-state logic; outputs come from mc_out_decode.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic [1:0]         pcsrc,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               halt,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_HLT:       state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec_ctrl)
  );

  // The state register resets to FETCH, whose decode asserts memread;
  // gating with rst keeps every output low for the whole reset pulse.
  assign ctrl = rst ? '0 : dec_ctrl;

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign pcsrc       = ctrl.pcsrc;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign regdst      = ctrl.regdst;
  assign memtoreg    = ctrl.memtoreg;
  assign regwrite    = ctrl.regwrite;
  assign halt        = ctrl.halt;
  assign state       = rst ? '0 : STATE_W'(state_q);

endmodule
